muldiv_seq: RTL and testbench

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It time-multiplexes a dedicated 32-bit alu instance, using only the ADDU (4'b0000) and SUBU (4'b0001) codes and the alu's r/c outputs, to run shift-add multiplication and restoring division. Signed operations get sign pre-correction and post-correction steps. Results land in HI/LO registers that the CPU datapath reads for mfhi/mflo.

---
 rtl/cpu_defs.sv | 22 ++
 rtl/muldiv_seq.sv | 169 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared encodings between the CPU datapath, the alu and the multiply/divide sequencer.
package cpu_defs;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_ITER   = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } md_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving an external shared alu.
// Shift-add multiply and restoring divide, with sign pre/post correction.
module muldiv_seq
  import cpu_defs::*;
#(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_aluc,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_c
);

  md_state_t         state, state_next, post_target;
  logic [1:0]        op_reg, op_next;
  logic              sa, sa_next, sb, sb_next;
  logic              lz, lz_next;
  logic [4:0]        cnt, cnt_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [DATA_W-1:0] hi_next, lo_next;

  logic              is_signed, is_div, fix_lo, fix_hi;
  logic              acc_signed;
  logic [DATA_W-1:0] div_s;
  logic              div_ok;

  assign is_signed  = op_reg[0];
  assign is_div     = op_reg[1];
  assign fix_lo     = is_signed & (sa ^ sb);
  // Remainder follows the dividend's sign; the product follows the sign product.
  assign fix_hi     = is_signed & (is_div ? sa : (sa ^ sb));
  assign acc_signed = op[0];

  assign div_s  = {hi[DATA_W-2:0], lo[DATA_W-1]};
  assign div_ok = hi[DATA_W-1] | ~alu_c;

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_reg <= MD_MULTU;
      sa     <= 1'b0;
      sb     <= 1'b0;
      lz     <= 1'b0;
      cnt    <= 5'd0;
      b_reg  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_next;
      op_reg <= op_next;
      sa     <= sa_next;
      sb     <= sb_next;
      lz     <= lz_next;
      cnt    <= cnt_next;
      b_reg  <= b_next;
      hi     <= hi_next;
      lo     <= lo_next;
    end
  end

  always_comb begin
    state_next  = state;
    op_next     = op_reg;
    sa_next     = sa;
    sb_next     = sb;
    lz_next     = lz;
    cnt_next    = cnt;
    b_next      = b_reg;
    hi_next     = hi;
    lo_next     = lo;
    alu_a       = '0;
    alu_b       = '0;
    alu_aluc    = ALUC_ADDU;
    post_target = fix_lo ? ST_NEG_LO : (fix_hi ? ST_NEG_HI : ST_DONE);

    case (state)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (start) begin
          op_next  = op;
          sa_next  = acc_signed & a[DATA_W-1];
          sb_next  = acc_signed & b[DATA_W-1];
          lz_next  = 1'b0;
          cnt_next = 5'd0;
          b_next   = b;
          hi_next  = '0;
          lo_next  = a;
          if (op[1] && (b == '0)) begin
            state_next = ST_DONE;
            hi_next    = a;
            lo_next    = DIV0_LO;
          end else if (acc_signed && a[DATA_W-1]) begin
            state_next = ST_NEG_A;
          end else if (acc_signed && b[DATA_W-1]) begin
            state_next = ST_NEG_B;
          end else begin
            state_next = ST_ITER;
          end
        end
      end
      ST_NEG_A: begin
        alu_aluc   = ALUC_SUBU;
        alu_b      = lo;
        lo_next    = alu_r;
        state_next = sb ? ST_NEG_B : ST_ITER;
      end
      ST_NEG_B: begin
        alu_aluc   = ALUC_SUBU;
        alu_b      = b_reg;
        b_next     = alu_r;
        state_next = ST_ITER;
      end
      ST_ITER: begin
        if (is_div) begin
          alu_aluc = ALUC_SUBU;
          alu_a    = div_s;
          alu_b    = b_reg;
          hi_next  = div_ok ? alu_r : div_s;
          lo_next  = {lo[DATA_W-2:0], div_ok};
        end else begin
          alu_aluc = ALUC_ADDU;
          alu_a    = hi;
          alu_b    = lo[0] ? b_reg : '0;
          hi_next  = {alu_c, alu_r[DATA_W-1:1]};
          lo_next  = {alu_r[0], lo[DATA_W-1:1]};
        end
        cnt_next = cnt + 5'd1;
        if (cnt == 5'd31) state_next = post_target;
      end
      ST_NEG_LO: begin
        alu_aluc   = ALUC_SUBU;
        alu_b      = lo;
        lo_next    = alu_r;
        // No borrow out of 0-lo means lo was zero, so the carry ripples into hi.
        lz_next    = ~alu_c;
        state_next = fix_hi ? ST_NEG_HI : ST_DONE;
      end
      ST_NEG_HI: begin
        if (is_div) begin
          alu_aluc = ALUC_SUBU;
          alu_b    = hi;
        end else begin
          alu_aluc = ALUC_ADDU;
          alu_a    = ~hi;
          alu_b    = {{(DATA_W-1){1'b0}}, lz};
        end
        hi_next    = alu_r;
        state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ADDU/SUBU alu beside it.
module tb_muldiv_seq;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_r;
  logic        alu_c;

  int checks = 0;
  int failures = 0;
  int lat;
  int busy_cnt;

  always #5 clk = ~clk;

  // Reference alu: bit 32 of the 33-bit sum/difference is carry (ADDU) or borrow (SUBU).
  logic [32:0] alu_full;
  assign alu_full = (alu_aluc == ALUC_SUBU) ? ({1'b0, alu_a} - {1'b0, alu_b})
                                            : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_r = alu_full[31:0];
  assign alu_c = alu_full[32];

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_c(alu_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(inout int l, output int bc);
    bc = 0;
    while (!done && l < 200) begin
      if (busy) bc++;
      @(posedge clk); #1;
      l++;
    end
    if (!done) l = -1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int l, output int bc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 1;
    wait_done(l, bc);
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h latency=%0d", o, x, y, hi, lo, l);
  endtask

  initial begin
    #2;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("idle_alu", {alu_a, alu_b, alu_aluc}, 0);
    @(negedge clk); rst_n = 1'b1;

    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_cnt);
    check("multu_max_res", {hi, lo}, 64'hFFFFFFFE_00000001);
    check("multu_max_lat", lat, 33);
    check("multu_max_busy", busy_cnt, 32);
    check("done_alu", {alu_a, alu_b, alu_aluc}, 0);

    issue(MD_MULT, 32'hFFFFFFFD, 32'd5, lat, busy_cnt);
    check("mult_neg_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    check("mult_neg_lat", lat, 36);

    issue(MD_MULT, 32'h80000000, 32'h80000000, lat, busy_cnt);
    check("mult_min_res", {hi, lo}, 64'h40000000_00000000);
    check("mult_min_lat", lat, 35);

    issue(MD_MULT, 32'hFFFFFFFF, 32'd0, lat, busy_cnt);
    check("mult_zero_res", {hi, lo}, 64'h0);
    check("mult_zero_lat", lat, 36);

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, lat, busy_cnt);
    check("div_neg_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    check("div_neg_lat", lat, 36);

    issue(MD_DIVU, 32'd100, 32'd7, lat, busy_cnt);
    check("divu_res", {hi, lo}, 64'h00000002_0000000E);
    check("divu_lat", lat, 33);

    issue(MD_DIVU, 32'd100, 32'd0, lat, busy_cnt);
    check("divu0_res", {hi, lo}, 64'h00000064_FFFFFFFF);
    check("divu0_lat", lat, 1);

    issue(MD_DIV, 32'h80000000, 32'd0, lat, busy_cnt);
    check("div0_res", {hi, lo}, 64'h80000000_FFFFFFFF);
    check("div0_lat", lat, 1);

    // start pulsed mid-iteration must be ignored
    @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (10) @(posedge clk);
    lat += 10;
    @(negedge clk);
    op = MD_MULTU; a = 32'd5; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    wait_done(lat, busy_cnt);
    $display("ignored-start divu -> hi=%08h lo=%08h latency=%0d", hi, lo, lat);
    check("ignore_res", {hi, lo}, 64'h00000002_0000000E);
    check("ignore_lat", lat, 33);

    // start held through DONE: back-to-back accept
    @(negedge clk);
    op = MD_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    wait_done(lat, busy_cnt);
    $display("b2b first -> hi=%08h lo=%08h latency=%0d", hi, lo, lat);
    check("b2b1_res", {hi, lo}, 64'h0000000C);
    check("b2b1_lat", lat, 33);
    a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_pulse", done, 0);
    check("b2b_busy", busy, 1);
    lat = 1;
    wait_done(lat, busy_cnt);
    $display("b2b second -> hi=%08h lo=%08h gap=%0d", hi, lo, lat);
    check("b2b2_res", {hi, lo}, 64'h0000001E);
    check("b2b2_gap", lat, 33);

    // asynchronous reset during iteration
    @(negedge clk);
    op = MD_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-iteration -> hi=%08h lo=%08h busy=%0b done=%0b", hi, lo, busy, done);
    check("arst_hilo", {hi, lo}, 64'h0);
    check("arst_flags", {busy, done}, 2'b00);
    @(negedge clk); rst_n = 1'b1;

    issue(MD_MULTU, 32'd3, 32'd4, lat, busy_cnt);
    check("post_rst_res", {hi, lo}, 64'h0000000C);
    check("post_rst_lat", lat, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
